// File: rtl/mult_seq_ctrl.sv
// ============================================================================
// Module      : mult_seq_ctrl
// Description : Sequencer for an iterative W x W unsigned shift-and-add
//               multiplier that reuses one 2W-bit accumulate adder.
//               Optional macro APPROX_LSB_EN ORs the low APX_COLS columns
//               instead of adding them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_seq_ctrl #(
    parameter int W        = 8,
    parameter int APX_COLS = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   p,
    output logic             busy
);

    localparam int                 CNT_W      = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(W - 1);
    localparam logic [1:0]         S_IDLE     = 2'd0;
    localparam logic [1:0]         S_RUN      = 2'd1;
    localparam logic [1:0]         S_DONE     = 2'd2;

`ifdef APPROX_LSB_EN
    localparam int C_APX = APX_COLS;
`else
    localparam int C_APX = 0;
`endif

    logic [1:0]       state_q, state_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   a_sh_q, a_sh_d;
    logic [W-1:0]     b_sh_q, b_sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   p_q, p_d;
    logic [2*W-1:0]   sum_w;

    generate
        if ((APX_COLS < 0) || (APX_COLS > 2*W - 1)) begin : g_bad_apx_cols
            $error("mult_seq_ctrl: APX_COLS out of range 0..2W-1");
        end
    endgenerate

    // Approximate build: low columns are OR-compressed and feed no carry upward.
    generate
        if (C_APX == 0) begin : g_sum_exact
            assign sum_w = acc_q + a_sh_q;
        end else begin : g_sum_apx
            assign sum_w = {acc_q[2*W-1:C_APX] + a_sh_q[2*W-1:C_APX],
                            acc_q[C_APX-1:0]   | a_sh_q[C_APX-1:0]};
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (in_valid)              state_d = S_RUN;
            S_RUN:  if (cnt_q == C_CNT_LAST)   state_d = S_DONE;
            S_DONE: if (out_ready)             state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        busy      = (state_q == S_RUN);
        out_valid = (state_q == S_DONE);
    end

    assign p = p_q;

    always_comb begin
        acc_d  = acc_q;
        a_sh_d = a_sh_q;
        b_sh_d = b_sh_q;
        cnt_d  = cnt_q;
        p_d    = p_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d = {{W{1'b0}}, a};
                    b_sh_d = b;
                    acc_d  = '0;
                    cnt_d  = '0;
                end
            end
            S_RUN: begin
                acc_d  = b_sh_q[0] ? sum_w : acc_q;
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                // Product register updates only on the transition into DONE.
                if (cnt_q == C_CNT_LAST) begin
                    p_d = acc_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            a_sh_q <= '0;
            b_sh_q <= '0;
            cnt_q  <= '0;
            p_q    <= '0;
        end else begin
            acc_q  <= acc_d;
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            cnt_q  <= cnt_d;
            p_q    <= p_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
// ============================================================================
// Module      : tb_mult_seq_ctrl
// Description : Directed, table-driven bench for mult_seq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_seq_ctrl;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [2*W-1:0] exp_p;
        string          name;
    } vec_t;

    logic           clk       = 1'b0;
    logic           rst_n     = 1'b1;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b1;
    logic [W-1:0]   a         = '0;
    logic [W-1:0]   b         = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [2*W-1:0] p;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;

    mult_seq_ctrl #(.W(W), .APX_COLS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Issues one pair and returns at the first sample showing out_valid.
    task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic [2*W-1:0] exp, input string name);
        int n;
        int bcnt;
        int wt;
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        wt = 0;
        while (!in_ready && wt < 50) begin
            @(negedge clk);
            wt++;
        end
        check({name, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        check({name, "_rdy_drop"}, 32'(in_ready), 32'd0);
        bcnt = busy ? 1 : 0;
        n = 0;
        while (!out_valid && n < W + 4) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bcnt++;
        end
        check({name, "_latency"}, 32'(n), 32'(W));
        check({name, "_busy_cycles"}, 32'(bcnt), 32'(W));
        check({name, "_p"}, 32'(p), 32'(exp));
    endtask

    initial begin : main
        vec_t tbl[5];
        int   c1;
        int   c2;
        bit   got1;
        bit   got2;
        bit   prev_rdy;
        bit   seen;

        tbl[0] = '{a: 8'd13,  b: 8'd11,  exp_p: 16'd143,   name: "v13x11"};
        tbl[1] = '{a: 8'd255, b: 8'd255, exp_p: 16'd65025, name: "v255x255"};
        tbl[2] = '{a: 8'd0,   b: 8'd200, exp_p: 16'd0,     name: "v0x200"};
        tbl[3] = '{a: 8'd1,   b: 8'd1,   exp_p: 16'd1,     name: "v1x1"};
`ifdef APPROX_LSB_EN
        tbl[4] = '{a: 8'd15,  b: 8'd15,  exp_p: 16'd191,   name: "v15x15"};
`else
        tbl[4] = '{a: 8'd15,  b: 8'd15,  exp_p: 16'd225,   name: "v15x15"};
`endif

        // Asynchronous reset before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_p",         32'(p),         32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].exp_p, tbl[i].name);
            @(posedge clk);
            #1;
            check({tbl[i].name, "_idle"}, 32'({in_ready, out_valid}), 32'b10);
        end

        // Backpressure with a second request presented while blocked.
        @(negedge clk);
        out_ready = 1'b0;
        do_op(8'd7, 8'd9, 16'd63, "bp");
        @(negedge clk);
        a = 8'd200;
        b = 8'd200;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("bp_hold", 32'({out_valid, in_ready, p}), 32'({1'b1, 1'b0, 16'd63}));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", 32'({in_ready, out_valid}), 32'b10);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) seen = 1'b1;
        end
        check("bp_second_ignored", 32'(seen), 32'd0);

        // Reset three cycles into RUN.
        @(negedge clk);
        a = 8'd100;
        b = 8'd100;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_state", 32'({out_valid, busy, in_ready, p}),
              32'({1'b0, 1'b0, 1'b1, 16'd0}));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("midrst_no_product", 32'(seen), 32'd0);

        // Back-to-back with out_ready tied high.
        @(negedge clk);
        out_ready = 1'b1;
        a = 8'd2;
        b = 8'd3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        c1 = cyc;
        a = 8'd4;
        b = 8'd5;
        prev_rdy = in_ready;
        got1 = 1'b0;
        got2 = 1'b0;
        c2 = -1;
        for (int i = 0; i < 40 && !got2; i++) begin
            @(posedge clk);
            #1;
            if (prev_rdy && in_valid) begin
                c2 = cyc;
                in_valid = 1'b0;
            end
            if (out_valid && !got1) begin
                got1 = 1'b1;
                check("b2b_p1", 32'(p), 32'd6);
            end else if (out_valid && got1 && c2 >= 0) begin
                got2 = 1'b1;
                check("b2b_p2", 32'(p), 32'd20);
            end
            prev_rdy = in_ready;
        end
        in_valid = 1'b0;
        check("b2b_both_done", 32'({got1, got2}), 32'b11);
        check("b2b_interval", 32'(c2 - c1), 32'd10);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
